mix_columns_seq: RTL and testbench
==================================

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 SHALL have parameter BYPASS_EN, default 1, meaning 1 enables the in_last bypass path and 0 ties bypass off.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the input state is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts an input this cycle.
REQ-006 SHALL have port in_state, input, 128 bits: AES state; column c = bits [127-32c -: 32]; byte r of a column at [31-8r -: 8].
REQ-007 SHALL have port in_last, input, 1 bit: final encryption round, so MixColumns is skipped.
REQ-008 SHALL have port out_valid, output, 1 bit: out_state holds a result.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port out_state, output, 128 bits: the forward-MixColumns result, or the bypassed state.

Function
REQ-011 SHALL implement forward (encryption) MixColumns per column: b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
REQ-012 SHALL compute GF(2^8) multiply by 2 as xtime(a) = {a[6:0],0} ^ (a[7] ? 8'h1b : 8'h00), and multiply by 3 as xtime(a)^a; no lookup tables.
REQ-013 SHALL use an FSM with states IDLE, BUSY, DONE.
REQ-014 SHALL assert in_ready only in IDLE; a transfer occurs when in_valid && in_ready.
REQ-015 On a transfer, SHALL register in_state into the working register, clear the 2-bit column counter col, and go to BUSY; if in_last && BYPASS_EN, it SHALL go directly to DONE instead.
REQ-016 In BUSY, SHALL replace working column col with its mixed value once per cycle, for col = 0,1,2,3 in order; after col==3 it SHALL go to DONE.
REQ-017 Latency from the transfer edge to out_valid=1 SHALL be 5 cycles for the normal path and 1 cycle for bypass.
REQ-018 SHALL assert out_valid only in DONE; out_state SHALL equal the working register and stay stable while out_valid && !out_ready.
REQ-019 SHALL go from DONE to IDLE on out_ready; in_ready SHALL rise the following cycle, so there is one idle cycle between jobs (throughput 1 per 6 cycles).
REQ-020 SHALL ignore in_valid outside IDLE: no state corruption, no counter disturbance.
REQ-021 SHALL ignore in_last when BYPASS_EN=0, always taking the 4-column path.
REQ-022 col SHALL wrap only through the BUSY->DONE transition; it SHALL never be observed above 3.

Reset
REQ-023 On rst_n low, SHALL asynchronously force: FSM=IDLE, col=0, working register=0, out_valid=0, out_state=0; in_ready SHALL be 1 once rst_n deasserts.
REQ-024 Reset asserted during BUSY or DONE SHALL abort the job with no output; the first transfer after release SHALL be processed normally.

Structure
REQ-025 Package aes_pkg SHALL hold the 128-bit state type, the 32-bit column type, the FSM state enum, the constant 8'h1b (AES_POLY), and the xtime/mul3 functions.
REQ-026 SHALL instantiate exactly one combinational sub-module, mix_column_fwd (32-bit column in, 32-bit column out), shared across the 4 BUSY cycles.

Verification
REQ-027 Transfer column-0 word db135345, other columns 0 -> after 5 cycles out_state[127:96]=8e4da1bc, other columns 0.
REQ-028 Transfer d4bf5d30 e0b452ae b84111f1 1e2798e5 (FIPS-197 round 1) -> out_state = 046681e5 e0cb199a 48f8d37a 2806264c; also columns f20a225c->9fdc589d, 01010101->01010101, c6c6c6c6->c6c6c6c6.
REQ-029 Same input with in_last=1, BYPASS_EN=1 -> out_valid after 1 cycle and out_state equals the input; with BYPASS_EN=0 -> the mixed result after 5 cycles.
REQ-030 Hold out_ready=0 for 10 cycles in DONE while toggling in_valid with random data -> out_state stable, in_ready=0, result unchanged when finally accepted.
REQ-031 Assert rst_n low at BUSY col==2 -> out_valid=0, out_state=0, in_ready=1 after release; the next job, d4d4d4d5, gives d5d5d7d6.
REQ-032 Back-to-back jobs with in_valid and out_ready held high -> transfers exactly every 6 cycles, results in order and correct.

Source files
------------

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types, constants and GF(2^8) helpers for the AES MixColumns datapath.
//   state_t  : 128-bit AES state, column c at [127-32c -: 32]
//   col_t    : 32-bit column, byte r at [31-8r -: 8]
//   fsm_e    : sequencer states IDLE / BUSY / DONE
//   AES_POLY : reduction constant for xtime (x^8 = x^4 + x^3 + x + 1)
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam logic [7:0] AES_POLY = 8'h1b;

  // Multiply by 2 in GF(2^8): shift left, fold the carry back with the polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by 3 in GF(2^8): 3a = 2a + a.
  function automatic logic [7:0] mul3(input logic [7:0] a);
    return xtime(a) ^ a;
  endfunction

endpackage

// File: rtl/mix_column_fwd.sv
// ---------------------------------------------------------------------------
// mix_column_fwd
// Purely combinational forward MixColumns on one 32-bit column.
//   col_i : input column, byte r at [31-8r -: 8]
//   col_o : mixed column, same byte layout
// ---------------------------------------------------------------------------
module mix_column_fwd
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0_s, a1_s, a2_s, a3_s;
  col_t       mixed_s;

  // Split the column into its four bytes.
  always_comb begin
    a0_s = col_i[31:24];
    a1_s = col_i[23:16];
    a2_s = col_i[15:8];
    a3_s = col_i[7:0];
  end

  // Circulant matrix {2,3,1,1} applied to the column.
  always_comb begin
    mixed_s[31:24] = xtime(a0_s) ^ mul3(a1_s)  ^ a2_s        ^ a3_s;
    mixed_s[23:16] = a0_s        ^ xtime(a1_s) ^ mul3(a2_s)  ^ a3_s;
    mixed_s[15:8]  = a0_s        ^ a1_s        ^ xtime(a2_s) ^ mul3(a3_s);
    mixed_s[7:0]   = mul3(a0_s)  ^ a1_s        ^ a2_s        ^ xtime(a3_s);
  end

  assign col_o = mixed_s;

endmodule

// File: rtl/mix_columns_seq.sv
// ---------------------------------------------------------------------------
// mix_columns_seq
// Sequential AES forward MixColumns: one shared column mixer processes the four
// columns of the working register over four BUSY cycles. A final-round job
// (in_last with BYPASS_EN=1) skips mixing and is presented unchanged.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake (in_ready only in IDLE)
//   in_state, in_last   : 128-bit state and final-round flag
//   out_valid/out_ready : output handshake (out_valid only in DONE)
//   out_state           : working register (mixed or bypassed state)
// ---------------------------------------------------------------------------
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int unsigned BYPASS_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam logic BYPASS_ON = (BYPASS_EN != 32'd0);

  fsm_e        state_q, state_d;
  logic [1:0]  col_q, col_d;
  state_t      work_q, work_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] col_in_s;
  logic [31:0] col_out_s;

  // Route the column addressed by col to the shared mixer.
  always_comb begin
    col_in_s = 32'h0000_0000;
    case (col_q)
      2'd0:    col_in_s = work_q[127:96];
      2'd1:    col_in_s = work_q[95:64];
      2'd2:    col_in_s = work_q[63:32];
      2'd3:    col_in_s = work_q[31:0];
      default: col_in_s = 32'h0000_0000;
    endcase
  end

  mix_column_fwd u_mix (
    .col_i (col_in_s),
    .col_o (col_out_s)
  );

  // Next-state, counter and working-register update.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          work_d = in_state;
          col_d  = 2'd0;
          if (in_last && BYPASS_ON) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        case (col_q)
          2'd0:    work_d[127:96] = col_out_s;
          2'd1:    work_d[95:64]  = col_out_s;
          2'd2:    work_d[63:32]  = col_out_s;
          2'd3:    work_d[31:0]   = col_out_s;
          default: work_d         = work_q;
        endcase
        // The 2-bit counter wraps 3->0 on exactly the cycle that leaves BUSY.
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        col_d   = 2'd0;
      end
    endcase
  end

  // Handshake flags are decoded from the next state so they leave a flop.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, counter, working register and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      work_q      <= 128'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      work_q      <= work_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid_v  [2];
  logic         in_ready_v  [2];
  logic [127:0] in_state_v  [2];
  logic         in_last_v   [2];
  logic         out_valid_v [2];
  logic         out_ready_v [2];
  logic [127:0] out_state_v [2];

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  // Instance 0: bypass enabled.
  mix_columns_seq #(.BYPASS_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_state(in_state_v[0]), .in_last(in_last_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_state(out_state_v[0])
  );

  // Instance 1: bypass disabled.
  mix_columns_seq #(.BYPASS_EN(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_state(in_state_v[1]), .in_last(in_last_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_state(out_state_v[1])
  );

  // ---------------- reference model ----------------
  // Generic GF(2^8) product by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x << 1) ^ ((x[7]) ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s);
    logic [7:0] m [4][4];
    logic [7:0] a [4];
    logic [7:0] b;
    logic [127:0] r = 128'd0;
    m[0] = '{8'd2, 8'd3, 8'd1, 8'd1};
    m[1] = '{8'd1, 8'd2, 8'd3, 8'd1};
    m[2] = '{8'd1, 8'd1, 8'd2, 8'd3};
    m[3] = '{8'd3, 8'd1, 8'd1, 8'd2};
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gmul(m[row][k], a[k]);
        r[127 - 32*c - 8*row -: 8] = b;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_job(input logic [127:0] s, input logic last, input int w);
    if (last && (w == 0)) return s;
    return ref_mix(s);
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int w, input logic [127:0] d, input logic last, output int lat);
    int n = 0;
    while (in_ready_v[w] !== 1'b1 && n < 20) begin step(); n++; end
    chk("in_ready_wait", {127'd0, in_ready_v[w]}, 128'd1);
    in_valid_v[w] = 1'b1;
    in_state_v[w] = d;
    in_last_v[w]  = last;
    step();
    in_valid_v[w] = 1'b0;
    in_last_v[w]  = 1'b0;
    lat = 1;
    while (out_valid_v[w] !== 1'b1 && lat < 20) begin step(); lat++; end
  endtask

  task automatic finish_job(input int w);
    out_ready_v[w] = 1'b1;
    step();
    out_ready_v[w] = 1'b0;
  endtask

  task automatic run_job(input int w, input logic [127:0] d, input logic last,
                         output logic [127:0] res, output int lat);
    start_job(w, d, last, lat);
    res = out_state_v[w];
    finish_job(w);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] res, d, held;
    logic [127:0] bq [4];
    int lat, w, sent, recv, cyc;
    int xc [4];
    logic last;

    for (int i = 0; i < 2; i++) begin
      in_valid_v[i] = 1'b0; in_state_v[i] = 128'd0;
      in_last_v[i] = 1'b0;  out_ready_v[i] = 1'b0;
    end
    rst_n = 1'b0;
    #12;
    chk("reset_out_valid", {127'd0, out_valid_v[0]}, 128'd0);
    chk("reset_out_state", out_state_v[0], 128'd0);
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("reset_in_ready", {127'd0, in_ready_v[0]}, 128'd1);

    // Single non-zero column.
    run_job(0, {32'hdb135345, 96'd0}, 1'b0, res, lat);
    chk("col0_result", res, {32'h8e4da1bc, 96'd0});
    chk("col0_latency", lat, 5);

    // FIPS-197 round 1 state.
    run_job(0, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, res, lat);
    chk("fips_result", res, 128'h046681e5_e0cb199a_48f8d37a_2806264c);

    // Extra known columns packed into one job.
    run_job(0, 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5, 1'b0, res, lat);
    chk("known_cols", res, 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6);

    // Final-round bypass with BYPASS_EN=1 and ignored with BYPASS_EN=0.
    d = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    run_job(0, d, 1'b1, res, lat);
    chk("bypass_result", res, d);
    chk("bypass_latency", lat, 1);
    run_job(1, d, 1'b1, res, lat);
    chk("nobypass_result", res, 128'h046681e5_e0cb199a_48f8d37a_2806264c);
    chk("nobypass_latency", lat, 5);

    // Backpressure in DONE while in_valid toggles with junk.
    d = {$urandom, $urandom, $urandom, $urandom};
    start_job(0, d, 1'b0, lat);
    held = out_state_v[0];
    chk("hold_initial", held, ref_mix(d));
    for (int i = 0; i < 10; i++) begin
      in_valid_v[0] = i[0];
      in_state_v[0] = {$urandom, $urandom, $urandom, $urandom};
      in_last_v[0]  = 1'(($urandom % 2));
      step();
      chk("hold_state", out_state_v[0], held);
      chk("hold_in_ready", {127'd0, in_ready_v[0]}, 128'd0);
      chk("hold_out_valid", {127'd0, out_valid_v[0]}, 128'd1);
    end
    in_valid_v[0] = 1'b0; in_last_v[0] = 1'b0;
    chk("hold_accept", out_state_v[0], ref_mix(d));
    finish_job(0);

    // Reset while BUSY at column 2.
    while (in_ready_v[0] !== 1'b1) step();
    in_valid_v[0] = 1'b1;
    in_state_v[0] = 128'h11223344_55667788_99aabbcc_ddeeff00;
    step();
    in_valid_v[0] = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #2;
    chk("abort_out_valid", {127'd0, out_valid_v[0]}, 128'd0);
    chk("abort_out_state", out_state_v[0], 128'd0);
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("abort_in_ready", {127'd0, in_ready_v[0]}, 128'd1);
    run_job(0, {32'hd4d4d4d5, 96'd0}, 1'b0, res, lat);
    chk("after_abort", res, {32'hd5d5d7d6, 96'd0});
    chk("after_abort_lat", lat, 5);

    // Random jobs on either instance against the model.
    for (int i = 0; i < 8; i++) begin
      w    = int'($urandom_range(0, 1));
      last = 1'($urandom % 2);
      d    = {$urandom, $urandom, $urandom, $urandom};
      run_job(w, d, last, res, lat);
      chk("rand_result", res, ref_job(d, last, w));
      chk("rand_latency", lat, (last && w == 0) ? 1 : 5);
    end

    // Back-to-back with in_valid and out_ready held high.
    for (int i = 0; i < 4; i++) bq[i] = {$urandom, $urandom, $urandom, $urandom};
    while (in_ready_v[0] !== 1'b1) step();
    sent = 0; recv = 0; cyc = 0;
    in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b1;
    while (recv < 4 && cyc < 100) begin
      if (in_ready_v[0] === 1'b1 && sent < 4) begin
        in_state_v[0] = bq[sent];
        xc[sent] = cyc;
        sent++;
      end else if (sent >= 4) begin
        in_valid_v[0] = 1'b0;
      end
      if (out_valid_v[0] === 1'b1) begin
        chk("b2b_result", out_state_v[0], ref_mix(bq[recv]));
        recv++;
      end
      step();
      cyc++;
    end
    in_valid_v[0] = 1'b0; out_ready_v[0] = 1'b0;
    chk("b2b_count", recv, 4);
    for (int i = 0; i < 3; i++) chk("b2b_spacing", xc[i+1] - xc[i], 6);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
